// File: rtl/sram_stream_adapter.sv
// ============================================================================
//  Module   : sram_stream_adapter
//  Purpose  : Valid/ready front-end for a 1-cycle-latency SRAM. Read data is
//             captured into a credit-checked response FIFO so that no read
//             data is lost when the response consumer stalls.
//             Define SRAM_STREAM_ADAPTER_BYPASS_EN for a 1-cycle read path
//             that skips the FIFO when it is empty.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_stream_adapter #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int NUM_WORDS  = 1024,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic                          req_we_i,
    input  logic [$clog2(NUM_WORDS)-1:0]  req_addr_i,
    input  logic [DATA_WIDTH-1:0]         req_wdata_i,
    input  logic [USER_WIDTH-1:0]         req_wuser_i,
    input  logic [(DATA_WIDTH+7)/8-1:0]   req_be_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
    output logic [USER_WIDTH-1:0]         rsp_ruser_o,
    output logic                          sram_req_o,
    output logic                          sram_we_o,
    output logic [$clog2(NUM_WORDS)-1:0]  sram_addr_o,
    output logic [DATA_WIDTH-1:0]         sram_wdata_o,
    output logic [USER_WIDTH-1:0]         sram_wuser_o,
    output logic [(DATA_WIDTH+7)/8-1:0]   sram_be_o,
    input  logic [DATA_WIDTH-1:0]         sram_rdata_i,
    input  logic [USER_WIDTH-1:0]         sram_ruser_i,
    output logic                          idle_o
);

    localparam int EW = DATA_WIDTH + USER_WIDTH;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [EW-1:0] mem_q [RSP_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_pending_q, rd_pending_d;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_fifo_pop;
    logic          w_rd_ok;
    logic          w_accept;
    logic [EW-1:0] w_head;
    logic [CW:0]   w_credit;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == CW'(RSP_DEPTH));
    assign w_head  = mem_q[rptr_q];

    always_comb begin
        rsp_valid_o = 1'b0;
        rsp_rdata_o = w_head[DATA_WIDTH-1:0];
        rsp_ruser_o = w_head[EW-1:DATA_WIDTH];
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_fifo_pop  = 1'b0;
`ifdef SRAM_STREAM_ADAPTER_BYPASS_EN
        // Empty FIFO with data arriving: present the SRAM output directly.
        if (rd_pending_q && w_empty) begin
            rsp_valid_o = !rst_i;
            rsp_rdata_o = sram_rdata_i;
            rsp_ruser_o = sram_ruser_i;
            w_pop       = rsp_valid_o & rsp_ready_i;
            w_push      = !w_pop;
        end else begin
            rsp_valid_o = !rst_i & !w_empty;
            w_pop       = rsp_valid_o & rsp_ready_i;
            w_fifo_pop  = w_pop;
            w_push      = rd_pending_q;
        end
`else
        rsp_valid_o = !rst_i & !w_empty;
        w_pop       = rsp_valid_o & rsp_ready_i;
        w_fifo_pop  = w_pop;
        w_push      = rd_pending_q;
`endif
    end

    // A read is admitted only if its data is guaranteed a FIFO slot next cycle.
    assign w_credit    = {1'b0, count_q} + (CW+1)'(rd_pending_q) - (CW+1)'(w_pop);
    assign w_rd_ok     = (w_credit < (CW+1)'(RSP_DEPTH));
    assign req_ready_o = !rst_i & (req_we_i | w_rd_ok);
    assign w_accept    = req_valid_i & req_ready_o;

    assign sram_req_o   = w_accept;
    assign sram_we_o    = req_we_i;
    assign sram_addr_o  = req_addr_i;
    assign sram_wdata_o = req_wdata_i;
    assign sram_wuser_o = req_wuser_i;
    assign sram_be_o    = req_be_i;

    assign idle_o = rst_i | (!rd_pending_q & w_empty);

    always_comb begin
        rd_pending_d = w_accept & !req_we_i;
        count_d      = count_q + CW'(w_push) - CW'(w_fifo_pop);
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        if (w_push) begin
            wptr_d = (wptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
        end
        if (w_fifo_pop) begin
            rptr_d = (rptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_pending_q <= 1'b0;
            count_q      <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
        end else begin
            assert (!(w_push && w_full));
            rd_pending_q <= rd_pending_d;
            count_q      <= count_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wptr_q] <= {sram_ruser_i, sram_rdata_i};
        end
    end

endmodule

`default_nettype wire
